// File: rtl/gpr_pkg.sv
// Shared sizing defaults for the GPR writeback arbiter and its scoreboard.
package gpr_pkg;

    localparam int unsigned NREG_DEF         = 32;
    localparam int unsigned AW_DEF           = 5;
    localparam int unsigned DW_DEF           = 32;
    localparam int unsigned STARVE_LIMIT_DEF = 4;
    localparam int unsigned R0               = 0;

endpackage

// File: rtl/gpr_scoreboard.sv
// Pending-MDU-destination mask with set/clear update and a 3-port hazard lookup.
module gpr_scoreboard
    import gpr_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned AW   = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_i,
    input  logic [AW-1:0] set_sel_i,
    input  logic          clr_i,
    input  logic [AW-1:0] clr_sel_i,
    input  logic [AW-1:0] rs_i,
    input  logic [AW-1:0] rt_i,
    input  logic [AW-1:0] dest_i,
    input  logic          dest_v_i,
    output logic          hazard_o
);

    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] pending_eff;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int i = 1; i < NREG; i++) begin
            set_vec[i] = set_i && (set_sel_i == AW'(i));
            clr_vec[i] = clr_i && (clr_sel_i == AW'(i));
        end
    end

    // Set beats clear so a back-to-back reissue to the same register stays pending.
    always_comb begin
        pending_d    = (pending_q & ~clr_vec) | set_vec;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // A result committing this cycle is bypassed by the register file, so it does not stall.
    always_comb begin
        pending_eff = pending_q & ~clr_vec;
        hazard_o    = 1'b0;
        if (rs_i != AW'(R0) && pending_eff[rs_i]) begin
            hazard_o = 1'b1;
        end
        if (rt_i != AW'(R0) && pending_eff[rt_i]) begin
            hazard_o = 1'b1;
        end
        if (dest_v_i && dest_i != AW'(R0) && pending_eff[dest_i]) begin
            hazard_o = 1'b1;
        end
    end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Arbitrates the single GPR write port between the WB stage and the MDU, with
// starvation-driven WB freeze and an MDU-destination scoreboard for ID stalls.
module gpr_wb_arbiter
    import gpr_pkg::*;
#(
    parameter int unsigned NREG         = NREG_DEF,
    parameter int unsigned AW           = AW_DEF,
    parameter int unsigned DW           = DW_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_sel,
    input  logic [DW-1:0] wb_data,
    input  logic          mdu_issue,
    input  logic [AW-1:0] mdu_issue_sel,
    input  logic          mdu_valid,
    input  logic [AW-1:0] mdu_sel,
    input  logic [DW-1:0] mdu_data,
    output logic          mdu_ready,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic [AW-1:0] id_dest,
    input  logic          id_dest_v,
    output logic          id_stall,
    output logic          wb_freeze,
    output logic          gpr_we,
    output logic [AW-1:0] gpr_wesel,
    output logic [DW-1:0] gpr_wdata,
    output logic          proto_err
);

    localparam int unsigned CW      = (STARVE_LIMIT > 2) ? $clog2(STARVE_LIMIT) : 1;
    localparam logic [CW-1:0] CntMax = CW'(STARVE_LIMIT - 1);

    logic          wb_act;
    logic          mdu_grant;
    logic          hazard;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic          wb_freeze_q, wb_freeze_d;
    logic          proto_err_q, proto_err_d;

    // A WB write to r0 is treated as idle and leaves the port to the MDU.
    assign wb_act    = wb_we && (wb_sel != AW'(R0));
    assign mdu_ready = !rst && !wb_act;
    assign mdu_grant = mdu_valid && mdu_ready;

    always_comb begin
        gpr_we    = 1'b0;
        gpr_wesel = '0;
        gpr_wdata = '0;
        if (!rst) begin
            if (wb_act) begin
                gpr_we    = 1'b1;
                gpr_wesel = wb_sel;
                gpr_wdata = wb_data;
            end else if (mdu_grant) begin
                gpr_we    = 1'b1;
                gpr_wesel = mdu_sel;
                gpr_wdata = mdu_data;
            end
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!mdu_valid || mdu_grant) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != CntMax) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
        wb_freeze_d = (starve_cnt_q == CntMax) && mdu_valid && !mdu_ready;
        proto_err_d = proto_err_q || (wb_freeze_q && wb_act);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
            wb_freeze_q  <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            wb_freeze_q  <= wb_freeze_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign wb_freeze = wb_freeze_q;
    assign proto_err = proto_err_q;

    gpr_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_i     (mdu_issue),
        .set_sel_i (mdu_issue_sel),
        .clr_i     (mdu_grant),
        .clr_sel_i (mdu_sel),
        .rs_i      (id_rs),
        .rt_i      (id_rt),
        .dest_i    (id_dest),
        .dest_v_i  (id_dest_v),
        .hazard_o  (hazard)
    );

    assign id_stall = !rst && hazard;

endmodule
